// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

    localparam int DATA_BITS          = 8;
    localparam int FRAME_BITS         = 11;
    localparam int SHIFT_BITS         = FRAME_BITS - 1;
    localparam int DEF_FILTER_LEN     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 20000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } ps2_state_e;

    // Shift register layout: [7:0] data LSB first, [8] parity, [9] stop.
    function automatic logic frame_ok(input logic [SHIFT_BITS-1:0] f);
        return (^f[DATA_BITS:0]) & f[SHIFT_BITS-1];
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 lines and turns a debounced kb_clk fall into a one-cycle strobe.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic reset_n,
    input  logic kb_clk,
    input  logic kb_data,
    output logic data_sync,
    output logic fe
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fe_q, fe_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (clk_s2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = clk_s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fe_d = level_q & ~level_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
            level_q   <= 1'b1;
            cnt_q     <= '0;
            fe_q      <= 1'b0;
        end else begin
            clk_s1_q  <= kb_clk;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= kb_data;
            data_s2_q <= data_s1_q;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            fe_q      <= fe_d;
        end
    end

    assign data_sync = data_s2_q;
    assign fe        = fe_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard frame receiver: start/data/parity/stop capture, check and watchdog abort.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 kb_clk,
    input  logic                 kb_data,
    output logic [DATA_BITS-1:0] scan_code,
    output logic                 scan_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    // Expire when the count is about to reach TIMEOUT_CYCLES-1, so the error
    // pulse lands TIMEOUT_CYCLES cycles after the last fe.
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [3:0]      LAST_BIT = 4'(SHIFT_BITS - 1);

    logic data_sync, fe;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .kb_clk   (kb_clk),
        .kb_data  (kb_data),
        .data_sync(data_sync),
        .fe       (fe)
    );

    ps2_state_e              state_q, state_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [SHIFT_BITS-1:0]   shift_q, shift_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [DATA_BITS-1:0]    scan_code_q, scan_code_d;
    logic                    scan_valid_q, scan_valid_d;
    logic                    frame_err_q, frame_err_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        wd_d         = wd_q;
        scan_code_d  = scan_code_q;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fe && !data_sync) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = '0;
                    wd_d      = '0;
                end
            end
            ST_RECV: begin
                if (fe) begin
                    shift_d   = {data_sync, shift_q[SHIFT_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    wd_d      = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_CHECK;
                    end
                end else if (wd_q == WD_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                    shift_d     = '0;
                    wd_d        = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (frame_ok(shift_q)) begin
                    scan_code_d  = shift_q[DATA_BITS-1:0];
                    scan_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
                state_d = ST_IDLE;
                wd_d    = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            wd_q         <= '0;
            scan_code_q  <= '0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            wd_q         <= wd_d;
            scan_code_q  <= scan_code_d;
            scan_valid_q <= scan_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q == ST_RECV) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: table vectors, random frames and corner sequences.
module tb_ps2_frame_receiver;

    localparam int FL   = 4;
    localparam int TO   = 500;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       kb_clk = 1'b1;
    logic       kb_data = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err, busy;

    ps2_frame_receiver #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .kb_clk    (kb_clk),
        .kb_data   (kb_data),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n_valid = 0, n_err = 0, n_both = 0;
    int valid_cyc = 0, err_cyc = 0, fe_cyc = 0, fall_cyc = 0;
    logic [7:0] model_code = 8'h00;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (dut.u_filter.fe_q) fe_cyc = cyc;
        if (scan_valid) begin n_valid++; valid_cyc = cyc; end
        if (frame_err) begin n_err++; err_cyc = cyc; end
        if (scan_valid && frame_err) n_both++;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL global_timeout actual=%0d cycles required=<90000", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        kb_data = b;
        wait_cyc(HALF);
        kb_clk = 1'b0;
        fall_cyc = cyc;
        wait_cyc(HALF);
        kb_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        kb_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic p,
                             input logic s, input int exp_valid, input logic [7:0] exp_code);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_frame(d, p, s);
        wait_cyc(10);
        check({name, "_valid_cnt"}, n_valid - v0, exp_valid);
        check({name, "_err_cnt"}, n_err - e0, 1 - exp_valid);
        check({name, "_scan_code"}, int'(scan_code), int'(exp_code));
        check({name, "_busy"}, int'(busy), 0);
        if (exp_valid == 1) check({name, "_valid_latency"}, valid_cyc - fe_cyc, 2);
        else                check({name, "_err_latency"}, err_cyc - fe_cyc, 2);
        check({name, "_fe_latency_ok"}, int'((fe_cyc - fall_cyc) <= FL + 3 && fe_cyc > fall_cyc), 1);
    endtask

    function automatic int model_ok(input logic [7:0] d, input logic p, input logic s);
        return ((($countones(d) + int'(p)) % 2) == 1 && s) ? 1 : 0;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        int         exp_valid;
        logic [7:0] exp_code;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int v0, e0;
        logic [7:0] d;
        logic p, s;
        int ok;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C};
        vecs[1] = '{8'hF0, 1'b1, 1'b1, 1, 8'hF0};
        vecs[2] = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C};
        vecs[3] = '{8'hF0, 1'b1, 1'b1, 1, 8'hF0};
        vecs[4] = '{8'h1C, 1'b1, 1'b1, 0, 8'hF0};
        vecs[5] = '{8'h1C, 1'b0, 1'b0, 0, 8'hF0};

        wait_cyc(5);
        check("rst_scan_code", int'(scan_code), 0);
        check("rst_scan_valid", int'(scan_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        wait_cyc(10);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].p, vecs[i].s,
                      vecs[i].exp_valid, vecs[i].exp_code);
        end
        model_code = 8'hF0;

        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            p = ($countones(d) % 2) == 0;
            if ($urandom_range(0, 3) == 0) p = ~p;
            s = ($urandom_range(0, 7) != 0);
            ok = model_ok(d, p, s);
            if (ok == 1) model_code = d;
            run_frame($sformatf("rnd%0d", i), d, p, s, ok, model_code);
        end

        // Aborted frame: 5 bits then the clock stays idle.
        v0 = n_valid;
        e0 = n_err;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        kb_data = 1'b1;
        for (int i = 0; i < 2000 && n_err == e0; i++) wait_cyc(1);
        check("timeout_err_cnt", n_err - e0, 1);
        check("timeout_latency", err_cyc - fe_cyc, TO);
        wait_cyc(2);
        check("timeout_busy", int'(busy), 0);
        check("timeout_valid_cnt", n_valid - v0, 0);
        check("timeout_scan_code", int'(scan_code), int'(model_code));
        model_code = 8'h32;
        run_frame("after_timeout", 8'h32, 1'b0, 1'b1, 1, model_code);

        // Short clock glitch must not start a frame; a long one must.
        v0 = n_valid;
        e0 = n_err;
        kb_data = 1'b0;
        wait_cyc(5);
        kb_clk = 1'b0;
        wait_cyc(FL - 1);
        kb_clk = 1'b1;
        wait_cyc(20);
        check("glitch_busy", int'(busy), 0);
        check("glitch_pulses", (n_valid - v0) + (n_err - e0), 0);
        kb_clk = 1'b0;
        wait_cyc(FL + 2);
        kb_clk = 1'b1;
        wait_cyc(10);
        check("long_pulse_busy", int'(busy), 1);
        kb_data = 1'b1;
        for (int i = 0; i < 1000 && n_err == e0; i++) wait_cyc(1);
        check("long_pulse_timeout", n_err - e0, 1);
        wait_cyc(2);
        check("long_pulse_idle", int'(busy), 0);

        // Reset in the middle of a frame.
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        wait_cyc(5);
        reset_n = 1'b0;
        wait_cyc(3);
        check("midrst_scan_code", int'(scan_code), 0);
        check("midrst_scan_valid", int'(scan_valid), 0);
        check("midrst_frame_err", int'(frame_err), 0);
        check("midrst_busy", int'(busy), 0);
        reset_n = 1'b1;
        model_code = 8'h00;
        wait_cyc(10);
        check("postrst_scan_code", int'(scan_code), int'(model_code));
        model_code = 8'h1C;
        run_frame("after_reset", 8'h1C, 1'b0, 1'b1, 1, model_code);

        check("valid_err_overlap", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
Receives 11-bit PS/2 keyboard frames on the kb_clk/kb_data lines and delivers each 8-bit scan code with a one-cycle valid strobe.
- Sequences bit capture on filtered falling edges of kb_clk.
- Checks start, odd parity and stop bits.
- Recovers from aborted frames with a watchdog.
- Sits between the board PS/2 pins and the scan-code decoder / display logic of the keyboard lab.

Parameters:
FILTER_LEN, 4, consecutive equal synchronized kb_clk samples required before the filtered level changes (glitch rejection)
TIMEOUT_CYCLES, 20000, clk cycles without a falling edge inside a frame before the frame is aborted (200 us at 100 MHz)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, synchronous, active-low
kb_clk  in  1  raw PS/2 clock from pin, asynchronous, idle high
kb_data  in  1  raw PS/2 data from pin, asynchronous, idle high
scan_code  out  8  last correctly received data byte; holds between frames
scan_valid  out  1  one-cycle pulse, scan_code updated this cycle
frame_err  out  1  one-cycle pulse on parity, stop or timeout error
busy  out  1  high while a frame is in progress (RECV or CHECK)

Behaviour:
- Reset is reset_n, synchronous, active-low; clock is clk. All logic is on posedge clk.
- Reset values: scan_code=0x00, scan_valid=0, frame_err=0, busy=0, FSM=IDLE, bit_cnt=0, watchdog=0. Filter state and sync flops reset to 1 (idle line).
- Input conditioning: kb_clk and kb_data each pass through a 2-FF synchronizer.
- Filtered clock level changes only after FILTER_LEN consecutive synchronized samples disagree with the current level.
- fe is a registered one-cycle strobe on a filtered 1->0 transition. Glitches shorter than FILTER_LEN cycles produce no fe.
- Data is sampled from synchronized kb_data in the fe cycle. PS/2 holds data stable for tens of microseconds around the clock edge, so no extra alignment is needed.
- Latency from kb_clk pin fall (stable) to fe: at most FILTER_LEN+3 cycles.
- Latency from fe of the stop bit to scan_valid/frame_err: exactly 2 cycles.
- FSM states:
  - IDLE: on fe with data=0 (start) -> RECV, bit_cnt=0, watchdog=0. On fe with data=1, stay in IDLE (spurious edge ignored).
  - RECV: on fe, shift the sample into an 10-bit shift register (8 data LSB first, then parity, then stop) and increment bit_cnt. On the fe where bit_cnt==9 (the stop bit) -> CHECK.
  - RECV watchdog: increments each cycle and clears on fe. Reaching TIMEOUT_CYCLES-1 -> frame_err pulse, IDLE, shift register discarded.
  - CHECK (1 cycle): valid if XOR(data[7:0], parity)==1 and stop==1. If valid, scan_code<=data and scan_valid pulse; otherwise frame_err pulse. Then -> IDLE.
- scan_valid and frame_err are never high in the same cycle and are never high for more than one cycle per frame.
- fe and watchdog expiry in the same cycle: fe wins, watchdog clears, no error.
- fe while in CHECK is dropped; legal PS/2 timing cannot produce this.
- On error, scan_code keeps its previous value.
- busy=1 in RECV and CHECK.
- reset_n low in any state (including mid-frame) returns to reset values on the next clk edge. A partial frame is discarded, and the next full frame after release is decoded normally.
- No host-to-device transmission; kb_clk and kb_data are inputs only.

Decomposition:
- Shared package ps2_pkg: FSM state encoding (IDLE, RECV, CHECK), DATA_BITS=8, FRAME_BITS=11, default FILTER_LEN and TIMEOUT_CYCLES.
- One sub-module is natural: ps2_line_filter. It takes raw kb_clk/kb_data and produces synchronized data, the filtered clock level and the fe strobe.
- The FSM, shift register, watchdog and checker stay in ps2_frame_receiver.

Test Plan:
- Valid frame 0x1C: 40 us bit period; start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1 -> exactly one scan_valid, scan_code=0x1C, frame_err never high, busy low afterwards.
- Break frame 0xF0 with parity 1, then 0x1C -> scan_valid twice, scan_code 0xF0 then 0x1C.
- Parity error: 0x1C sent with parity 1 after a good 0xF0 -> one frame_err pulse, no scan_valid, scan_code stays 0xF0. Stop bit 0 on otherwise valid 0x1C -> one frame_err.
- Timeout (TIMEOUT_CYCLES=500 in sim): 5 bits sent, then kb_clk held high -> frame_err exactly 500 cycles after the last fe, busy=0. Following valid 0x32 (parity 0) -> scan_code=0x32.
- Glitch: in IDLE with kb_data=0, kb_clk low pulse of FILTER_LEN-1 cycles -> busy stays 0, no pulses. A FILTER_LEN+2-cycle pulse -> busy=1.
- Reset mid-frame: reset_n low for 3 cycles after bit 4 -> all outputs 0, scan_code=0x00. Next full frame 0x1C -> decoded correctly.
